// File: rtl/binary_frame_sink_if.sv
// Bundles the binarized pixel stream, the row read port and the frame
// handshake/statistics between the upstream stage, this sink and the classifier.
interface binary_frame_sink_if #(
  parameter int IMG_W = 28,
  parameter int CW    = 10
);
  logic             bin_pixel;
  logic             bin_valid;
  logic             bin_frame_done;
  logic             rd_en;
  logic [4:0]       rd_addr;
  logic [IMG_W-1:0] rd_data;
  logic             rd_valid;
  logic             frame_ready;
  logic             frame_ack;
  logic [CW-1:0]    ones_count;
  logic [4:0]       bbox_xmin;
  logic [4:0]       bbox_xmax;
  logic [4:0]       bbox_ymin;
  logic [4:0]       bbox_ymax;
  logic             bbox_empty;
  logic             err_short;
  logic             err_overflow;

  modport slave (
    input  bin_pixel, bin_valid, bin_frame_done, rd_en, rd_addr, frame_ack,
    output rd_data, rd_valid, frame_ready, ones_count,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, bbox_empty,
           err_short, err_overflow
  );

  modport master (
    output bin_pixel, bin_valid, bin_frame_done, rd_en, rd_addr, frame_ack,
    input  rd_data, rd_valid, frame_ready, ones_count,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, bbox_empty,
           err_short, err_overflow
  );
endinterface

// File: rtl/binary_frame_sink.sv
// Packs a raster stream of 1-bit pixels into row words, tracks set-pixel count
// and bounding box, and holds each completed frame until the classifier acks it.
module binary_frame_sink #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  binary_frame_sink_if.slave  bus
);

  localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
  localparam logic [4:0] LAST_ROW = 5'(IMG_H - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [4:0]       col_reg, col_next, row_reg, row_next;
  logic [CW-1:0]    ones_reg, ones_next;
  logic [4:0]       xmin_reg, xmin_next, xmax_reg, xmax_next;
  logic [4:0]       ymin_reg, ymin_next, ymax_reg, ymax_next;
  logic             seen_reg, seen_next;
  logic [IMG_W-1:0] row_shift_reg, row_shift_next, row_word;

  logic [CW-1:0]    ones_count_reg, ones_count_next;
  logic [4:0]       bx_min_reg, bx_min_next, bx_max_reg, bx_max_next;
  logic [4:0]       by_min_reg, by_min_next, by_max_reg, by_max_next;
  logic             bbox_empty_reg, bbox_empty_next;
  logic             err_short_reg, err_short_next;
  logic             err_ovf_reg, err_ovf_next;

  logic [CW-1:0]    px_ones;
  logic [4:0]       px_xmin, px_xmax, px_ymin, px_ymax;
  logic             px_seen;
  logic             mem_we;

  logic [IMG_W-1:0] row_buf [IMG_H];
  logic [IMG_W-1:0] rd_data_reg;
  logic             rd_valid_reg;

  // Current row word with the incoming pixel already placed at its column.
  generate
    for (genvar gi = 0; gi < IMG_W; gi++) begin : g_row_word
      assign row_word[gi] = (col_reg == 5'(gi)) ? bus.bin_pixel : row_shift_reg[gi];
    end
  endgenerate

  // Running stats as they would be after accepting the current pixel.
  always_comb begin
    px_ones = ones_reg;
    px_xmin = xmin_reg;
    px_xmax = xmax_reg;
    px_ymin = ymin_reg;
    px_ymax = ymax_reg;
    px_seen = seen_reg;
    if (bus.bin_pixel) begin
      px_ones = ones_reg + CW'(1);
      px_seen = 1'b1;
      if (!seen_reg) begin
        px_xmin = col_reg;
        px_xmax = col_reg;
        px_ymin = row_reg;
        px_ymax = row_reg;
      end else begin
        // Raster order means ymin is fixed by the first set pixel.
        if (col_reg < xmin_reg) px_xmin = col_reg;
        if (col_reg > xmax_reg) px_xmax = col_reg;
        if (row_reg > ymax_reg) px_ymax = row_reg;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    col_next        = col_reg;
    row_next        = row_reg;
    ones_next       = ones_reg;
    xmin_next       = xmin_reg;
    xmax_next       = xmax_reg;
    ymin_next       = ymin_reg;
    ymax_next       = ymax_reg;
    seen_next       = seen_reg;
    row_shift_next  = row_shift_reg;
    ones_count_next = ones_count_reg;
    bx_min_next     = bx_min_reg;
    bx_max_next     = bx_max_reg;
    by_min_next     = by_min_reg;
    by_max_next     = by_max_reg;
    bbox_empty_next = bbox_empty_reg;
    err_short_next  = err_short_reg;
    err_ovf_next    = err_ovf_reg;
    mem_we          = 1'b0;

    case (state_reg)
      COLLECT: begin
        if (bus.bin_valid && col_reg == LAST_COL && row_reg == LAST_ROW) begin
          mem_we          = 1'b1;
          state_next      = HOLD;
          ones_count_next = px_ones;
          bbox_empty_next = !px_seen;
          bx_min_next     = px_seen ? px_xmin : 5'd0;
          bx_max_next     = px_seen ? px_xmax : 5'd0;
          by_min_next     = px_seen ? px_ymin : 5'd0;
          by_max_next     = px_seen ? px_ymax : 5'd0;
        end else if (bus.bin_frame_done) begin
          err_short_next = 1'b1;
        end else if (bus.bin_valid) begin
          ones_next = px_ones;
          xmin_next = px_xmin;
          xmax_next = px_xmax;
          ymin_next = px_ymin;
          ymax_next = px_ymax;
          seen_next = px_seen;
          if (col_reg == LAST_COL) begin
            mem_we         = 1'b1;
            col_next       = 5'd0;
            row_next       = row_reg + 5'd1;
            row_shift_next = '0;
          end else begin
            col_next       = col_reg + 5'd1;
            row_shift_next = row_word;
          end
        end
        // Completion and short frame both restart collection from scratch.
        if ((bus.bin_valid && col_reg == LAST_COL && row_reg == LAST_ROW) ||
            bus.bin_frame_done) begin
          col_next       = 5'd0;
          row_next       = 5'd0;
          ones_next      = '0;
          xmin_next      = 5'd0;
          xmax_next      = 5'd0;
          ymin_next      = 5'd0;
          ymax_next      = 5'd0;
          seen_next      = 1'b0;
          row_shift_next = '0;
        end
      end
      HOLD: begin
        if (bus.bin_valid) err_ovf_next = 1'b1;
        if (bus.frame_ack) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= COLLECT;
      col_reg        <= 5'd0;
      row_reg        <= 5'd0;
      ones_reg       <= '0;
      xmin_reg       <= 5'd0;
      xmax_reg       <= 5'd0;
      ymin_reg       <= 5'd0;
      ymax_reg       <= 5'd0;
      seen_reg       <= 1'b0;
      row_shift_reg  <= '0;
      ones_count_reg <= '0;
      bx_min_reg     <= 5'd0;
      bx_max_reg     <= 5'd0;
      by_min_reg     <= 5'd0;
      by_max_reg     <= 5'd0;
      bbox_empty_reg <= 1'b0;
      err_short_reg  <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      ones_reg       <= ones_next;
      xmin_reg       <= xmin_next;
      xmax_reg       <= xmax_next;
      ymin_reg       <= ymin_next;
      ymax_reg       <= ymax_next;
      seen_reg       <= seen_next;
      row_shift_reg  <= row_shift_next;
      ones_count_reg <= ones_count_next;
      bx_min_reg     <= bx_min_next;
      bx_max_reg     <= bx_max_next;
      by_min_reg     <= by_min_next;
      by_max_reg     <= by_max_next;
      bbox_empty_reg <= bbox_empty_next;
      err_short_reg  <= err_short_next;
      err_ovf_reg    <= err_ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) row_buf[row_reg] <= row_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= bus.rd_en;
      if (bus.rd_en) rd_data_reg <= (bus.rd_addr <= LAST_ROW) ? row_buf[bus.rd_addr] : '0;
    end
  end

  assign bus.rd_data      = rd_data_reg;
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.frame_ready  = (state_reg == HOLD);
  assign bus.ones_count   = ones_count_reg;
  assign bus.bbox_xmin    = bx_min_reg;
  assign bus.bbox_xmax    = bx_max_reg;
  assign bus.bbox_ymin    = by_min_reg;
  assign bus.bbox_ymax    = by_max_reg;
  assign bus.bbox_empty   = bbox_empty_reg;
  assign bus.err_short    = err_short_reg;
  assign bus.err_overflow = err_ovf_reg;

endmodule

// File: doc/binary_frame_sink.md
Name: binary_frame_sink

Overview:
- Receives the 1-bit binarized pixel stream (pixel, valid, frame-done) produced by the binarization stage.
- Packs each raster-order row of IMG_W bits into one word of an internal row buffer.
- Computes per-frame statistics: set-pixel count and bounding box of set pixels.
- Holds the completed frame for the downstream classifier, which reads rows by address and releases the frame with an acknowledge.

Parameters:
IMG_W, 28, pixels per row (row word width)
IMG_H, 28, rows per frame
CW, 10, pixel/ones counter width; must satisfy 2^CW > IMG_W*IMG_H

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
bin_pixel  in  1  binarized pixel
bin_valid  in  1  bin_pixel valid this cycle
bin_frame_done  in  1  asserted by upstream together with the last pixel of a frame
rd_en  in  1  row read request
rd_addr  in  5  row index, 0..IMG_H-1
rd_data  out  IMG_W  row word; bit c = pixel in column c
rd_valid  out  1  rd_data valid, one cycle after rd_en
frame_ready  out  1  complete frame held, stats valid
frame_ack  in  1  consumer releases the held frame
ones_count  out  CW  number of set pixels in the held frame
bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  out  5 each  bounding box of set pixels, inclusive
bbox_empty  out  1  held frame contains no set pixel
err_short  out  1  sticky: bin_frame_done arrived before IMG_W*IMG_H pixels
err_overflow  out  1  sticky: pixel arrived while a frame was held

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0, bbox_empty=0, state COLLECT, column/row/ones counters 0, row shift register 0. Row buffer contents are not reset.
- States:
  - COLLECT: accepts pixels.
  - HOLD: frame complete, waiting for frame_ack.
- COLLECT, on bin_valid:
  - bin_pixel shifts into bit col of the row register.
  - col increments. At col==IMG_W-1 the full word, including the current pixel, is written to buffer[row]; col resets to 0 and row increments.
  - If bin_pixel=1: ones increments; running xmin/xmax/ymin/ymax update. The first set pixel of a frame initialises all four.
- Frame completion: the valid pixel with row==IMG_H-1 and col==IMG_W-1 completes the frame, whether or not bin_frame_done accompanies it. On the next cycle:
  - state=HOLD, frame_ready=1.
  - ones_count and bbox outputs take the final values, including the last pixel.
  - bbox_empty=1 if ones==0; in that case all four bbox outputs are 0.
  - Internal counters clear.
- Short frame: bin_frame_done in COLLECT without completion, with or without bin_valid:
  - err_short is set.
  - Counters, row register and running bbox clear.
  - The pixel in that cycle is discarded.
  - State stays COLLECT; frame_ready stays 0.
- HOLD:
  - Any bin_valid sets err_overflow; the pixel is dropped and the buffer is untouched.
  - bin_frame_done alone is ignored.
  - frame_ack → next cycle state=COLLECT, frame_ready=0.
  - Stats outputs hold their values until the next frame completes.
  - bin_valid in the same cycle as frame_ack is still dropped and still flags overflow.
- frame_ack in COLLECT is ignored.
- Read port:
  - Usable in any state, one-cycle latency: rd_valid=rd_en delayed by one cycle; rd_data = buffer[rd_addr] registered.
  - rd_addr>=IMG_H returns all-zero data with rd_valid=1.
  - Contents are guaranteed only while frame_ready=1.
  - Back-to-back reads are supported at one per cycle.
- Sticky errors clear only on rst.
- Reset mid-frame discards the partial frame; the next accepted pixel is row 0, col 0.
- Latency: last pixel → frame_ready in 1 cycle; frame_ack → accepting in 1 cycle.

Test Plan:
- All-zero frame: 784 pixels of 0, frame_done on the last → frame_ready next cycle; ones_count=0; bbox_empty=1; bbox outputs 0; reads of rows 0..27 return 0.
- Single set pixel at row 3, col 5 → ones_count=1; xmin=xmax=5; ymin=ymax=3; rd_addr=3 gives 28'h0000020; other rows read 0.
- Checkerboard (pixel = (row+col)&1), valid gapped every other cycle → ones_count=392; bbox 0..27 in both axes; row 0 reads 28'hAAAAAAA; row 1 reads 28'h5555555.
- Short frame: 100 pixels, then frame_done → err_short=1, no frame_ready. A following full frame with one pixel at (0,0) → ones_count=1, bbox 0/0/0/0.
- Overflow: after frame_ready, 10 pixels of 1 without ack → err_overflow=1; rows and stats unchanged. frame_ack → frame_ready drops next cycle and the next frame is collected correctly.
- Reset mid-frame: assert rst after 400 pixels → all outputs 0. A full frame of 1s afterwards → ones_count=784; every row reads 28'hFFFFFFF.
